// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths and load-size encodings for the write-back stage
package wb_stage_pkg;
  localparam int BYTE_WIDTH        = 8;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int REGISTER_ADDR     = 5;
  localparam int CNT_WIDTH         = 32;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: picks the addressed byte/half lane of a little-endian word and extends it
module load_align
  import wb_stage_pkg::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0] word,
  input  logic [1:0]                   off,
  input  logic [1:0]                   size,
  input  logic                         is_unsigned,
  output logic [INSTRUCTION_WIDTH-1:0] data,
  output logic                         misaligned
);
  logic [INSTRUCTION_WIDTH-1:0] sh;
  logic [BYTE_WIDTH-1:0]        b;
  logic [2*BYTE_WIDTH-1:0]      h;
  always_comb begin
    sh = word >> {off, 3'b000};
    b  = sh[BYTE_WIDTH-1:0];
    h  = off[1] ? word[INSTRUCTION_WIDTH-1:2*BYTE_WIDTH] : word[2*BYTE_WIDTH-1:0];
    data = (size == LS_BYTE) ? {{(INSTRUCTION_WIDTH-BYTE_WIDTH){~is_unsigned & b[BYTE_WIDTH-1]}}, b} :
           (size == LS_HALF) ? {{(INSTRUCTION_WIDTH-2*BYTE_WIDTH){~is_unsigned & h[2*BYTE_WIDTH-1]}}, h} :
           word;
    misaligned = (size == LS_HALF & off[0]) | (size == LS_WORD & off != 2'b00) | (size == 2'b11);
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register and register-file write driver with retired-instruction counter
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         mem_valid,
  input  logic                         mem_reg_write,
  input  logic                         mem_to_reg,
  input  logic [REGISTER_ADDR-1:0]     mem_rd_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_alu_result,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_load_data,
  input  logic [1:0]                   mem_load_size,
  input  logic                         mem_load_unsigned,
  output logic [REGISTER_ADDR-1:0]     wb_addr,
  output logic [INSTRUCTION_WIDTH-1:0] w_data,
  output logic                         wb_en,
  output logic                         wb_valid,
  output logic                         misaligned_load,
  output logic [CNT_WIDTH-1:0]         instret
);
  logic [INSTRUCTION_WIDTH-1:0] ld_data, sel_data;
  logic                         ld_mis, mis, en, vld, cap;
  logic [REGISTER_ADDR-1:0]     wb_addr_d, wb_addr_q;
  logic [INSTRUCTION_WIDTH-1:0] w_data_d, w_data_q;
  logic                         wb_en_d, wb_en_q, wb_valid_d, wb_valid_q, mis_d, mis_q;
  logic [CNT_WIDTH-1:0]         instret_d, instret_q;

  load_align u_align (
    .word        (mem_load_data),
    .off         (mem_alu_result[1:0]),
    .size        (mem_load_size),
    .is_unsigned (mem_load_unsigned),
    .data        (ld_data),
    .misaligned  (ld_mis)
  );

  // Address and data are forced to 0 whenever no write occurs, since the bypass ignores wb_en.
  always_comb begin
    cap        = ~flush & ~stall;
    mis        = mem_valid & mem_to_reg & mem_reg_write & ld_mis;
    vld        = mem_valid & ~mis;
    en         = vld & mem_reg_write & (mem_rd_addr != '0);
    sel_data   = mem_to_reg ? ld_data : mem_alu_result;
    wb_addr_d  = flush ? '0 : stall ? wb_addr_q  : (en ? mem_rd_addr : '0);
    w_data_d   = flush ? '0 : stall ? w_data_q   : (en ? sel_data : '0);
    wb_en_d    = flush ? 1'b0 : stall ? wb_en_q    : en;
    wb_valid_d = flush ? 1'b0 : stall ? wb_valid_q : vld;
    mis_d      = flush ? 1'b0 : stall ? mis_q      : mis;
    instret_d  = instret_q + {{(CNT_WIDTH-1){1'b0}}, cap & vld};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr_q  <= '0;
      w_data_q   <= '0;
      wb_en_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      instret_q  <= '0;
    end else begin
      wb_addr_q  <= wb_addr_d;
      w_data_q   <= w_data_d;
      wb_en_q    <= wb_en_d;
      wb_valid_q <= wb_valid_d;
      mis_q      <= mis_d;
      instret_q  <= instret_d;
    end
  end

  assign wb_addr         = wb_addr_q;
  assign w_data          = w_data_q;
  assign wb_en           = wb_en_q;
  assign wb_valid        = wb_valid_q;
  assign misaligned_load = mis_q;
  assign instret         = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors checked against a behavioural write-back model and literal expectations
module tb_wb_stage;
  logic        clk = 0, rst = 1, stall = 0, flush = 0;
  logic        mem_valid = 0, mem_reg_write = 0, mem_to_reg = 0, mem_load_unsigned = 0;
  logic [4:0]  mem_rd_addr = 0;
  logic [31:0] mem_alu_result = 0, mem_load_data = 0;
  logic [1:0]  mem_load_size = 0;
  logic [4:0]  wb_addr;
  logic [31:0] w_data, instret;
  logic        wb_en, wb_valid, misaligned_load;

  int n_cmp = 0, n_err = 0;
  bit chk_on = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0, m_cnt = 0;
  logic        m_en = 0, m_valid = 0, m_mis = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg),
    .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_load_size(mem_load_size), .mem_load_unsigned(mem_load_unsigned),
    .wb_addr(wb_addr), .w_data(w_data), .wb_en(wb_en), .wb_valid(wb_valid),
    .misaligned_load(misaligned_load), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: load value from arithmetic on the byte address, not lane muxing.
  function automatic void model_load(input logic [31:0] word, input int off, input int size,
                                     input bit uns, output logic [31:0] val, output bit bad);
    int nbytes;
    longint unsigned v;
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    bad = (size == 3) || (off % nbytes != 0);
    v = (longint'(word) >> (8 * off)) % (longint'(1) << (8 * nbytes));
    if (!uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1))) v = v + 64'hFFFF_FFFF - ((longint'(1) << (8 * nbytes)) - 1);
    val = v[31:0];
  endfunction

  always @(posedge clk) begin
    logic [31:0] ld;
    bit bad, trap, retire, write;
    model_load(mem_load_data, int'(mem_alu_result[1:0]), int'(mem_load_size), mem_load_unsigned, ld, bad);
    trap   = mem_valid && mem_to_reg && mem_reg_write && bad;
    retire = mem_valid && !trap;
    write  = retire && mem_reg_write && mem_rd_addr != 0;
    if (rst) begin
      m_addr = 0; m_data = 0; m_en = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (flush) begin
      m_addr = 0; m_data = 0; m_en = 0; m_valid = 0; m_mis = 0;
    end else if (!stall) begin
      m_en = write; m_valid = retire; m_mis = trap;
      m_addr = write ? mem_rd_addr : 0;
      m_data = write ? (mem_to_reg ? ld : mem_alu_result) : 0;
      if (retire) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("model wb_addr", 32'(wb_addr), 32'(m_addr));
    chk("model w_data", w_data, m_data);
    chk("model wb_en", 32'(wb_en), 32'(m_en));
    chk("model wb_valid", 32'(wb_valid), 32'(m_valid));
    chk("model misaligned", 32'(misaligned_load), 32'(m_mis));
    chk("model instret", instret, m_cnt);
  end

  task automatic apply(input bit v, input bit rw, input bit tr, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] sz,
                       input bit uns, input bit st, input bit fl);
    mem_valid = v; mem_reg_write = rw; mem_to_reg = tr; mem_rd_addr = rd;
    mem_alu_result = alu; mem_load_data = ld; mem_load_size = sz; mem_load_unsigned = uns;
    stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic outs(input string n, input logic [4:0] a, input logic [31:0] d,
                      input bit e, input bit v, input bit m, input logic [31:0] c);
    chk({n, " wb_addr"}, 32'(wb_addr), 32'(a));
    chk({n, " w_data"}, w_data, d);
    chk({n, " wb_en"}, 32'(wb_en), 32'(e));
    chk({n, " wb_valid"}, 32'(wb_valid), 32'(v));
    chk({n, " misaligned"}, 32'(misaligned_load), 32'(m));
    chk({n, " instret"}, instret, c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1;
    rst = 0;
    outs("reset", 0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 7, 32'h1234_5678, 0, 2'b10, 0, 0, 0);
    outs("alu write", 7, 32'h1234_5678, 1, 1, 0, 1);
    rst = 1;
    apply(1, 1, 0, 7, 32'h1234_5678, 0, 2'b10, 0, 0, 0);
    outs("mid reset", 0, 0, 0, 0, 0, 0);
    rst = 0;
    apply(1, 1, 0, 7, 32'h1234_5678, 0, 2'b10, 0, 0, 0);
    outs("alu again", 7, 32'h1234_5678, 1, 1, 0, 1);
    apply(1, 1, 1, 3, 32'h0000_1003, 32'h80FF_7F01, 2'b00, 0, 0, 0);
    outs("lb off3", 3, 32'hFFFF_FF80, 1, 1, 0, 2);
    apply(1, 1, 1, 3, 32'h0000_1003, 32'h80FF_7F01, 2'b00, 1, 0, 0);
    outs("lbu off3", 3, 32'h0000_0080, 1, 1, 0, 3);
    apply(1, 1, 1, 4, 32'h0000_1002, 32'h80FF_7F01, 2'b01, 0, 0, 0);
    outs("lh off2", 4, 32'hFFFF_80FF, 1, 1, 0, 4);
    apply(1, 1, 1, 4, 32'h0000_1000, 32'h80FF_7F01, 2'b01, 1, 0, 0);
    outs("lhu off0", 4, 32'h0000_7F01, 1, 1, 0, 5);
    apply(1, 1, 1, 6, 32'h0000_1001, 32'h80FF_7F01, 2'b00, 0, 0, 0);
    outs("lb off1", 6, 32'h0000_007F, 1, 1, 0, 6);
    apply(1, 1, 1, 6, 32'h0000_1000, 32'h80FF_7F01, 2'b10, 0, 0, 0);
    outs("lw off0", 6, 32'h80FF_7F01, 1, 1, 0, 7);
    apply(1, 1, 0, 0, 32'hDEAD_BEEF, 0, 2'b10, 0, 0, 0);
    outs("r0 write", 0, 0, 0, 1, 0, 8);
    apply(1, 1, 1, 5, 32'h0000_1002, 32'h1111_2222, 2'b10, 0, 0, 0);
    outs("lw misaligned", 0, 0, 0, 0, 1, 8);
    apply(1, 1, 1, 5, 32'h0000_1001, 32'h1111_2222, 2'b01, 0, 0, 0);
    outs("lh misaligned", 0, 0, 0, 0, 1, 8);
    apply(1, 1, 1, 5, 32'h0000_1000, 32'h1111_2222, 2'b11, 0, 0, 0);
    outs("reserved size", 0, 0, 0, 0, 1, 8);
    apply(0, 1, 0, 5, 32'h0000_0042, 0, 2'b10, 0, 0, 0);
    outs("invalid bubble", 0, 0, 0, 0, 0, 8);
    apply(1, 0, 1, 9, 32'h0000_1002, 0, 2'b10, 0, 0, 0);
    outs("no-write load", 0, 0, 0, 1, 0, 9);
    apply(1, 1, 0, 9, 32'hA5A5_0001, 0, 2'b10, 0, 0, 0);
    outs("pre-stall", 9, 32'hA5A5_0001, 1, 1, 0, 10);
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 0, 12, 32'h0BAD_0000 + i, 0, 2'b10, 0, 1, 0);
      outs("stall hold", 9, 32'hA5A5_0001, 1, 1, 0, 10);
    end
    apply(1, 1, 0, 12, 32'h0BAD_0000, 0, 2'b10, 0, 1, 1);
    outs("flush+stall", 0, 0, 0, 0, 0, 10);
    apply(1, 1, 0, 1, 32'h0000_0001, 0, 2'b10, 0, 0, 1);
    outs("flush", 0, 0, 0, 0, 0, 10);
    apply(1, 1, 0, 31, 32'hFFFF_FFFF, 0, 2'b10, 0, 0, 0);
    outs("r31 write", 31, 32'hFFFF_FFFF, 1, 1, 0, 11);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
